// File: rtl/pipe_register_pkg.sv
// Default geometry shared by every user of the pipe register.
package pipe_register_pkg;
    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_STAGES = 4;
endpackage

// File: rtl/pipe_register_stage.sv
// Purpose: one data+valid slot of the elastic pipe; loads its predecessor when enabled.
// Latency: 1 cycle per slot.
// Backpressure: holds its contents whenever load is low; flush drops valid, keeps data.
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             load,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_valid <= 1'b0;
            q_data  <= '0;
        end else if (flush) begin
            q_valid <= 1'b0;
        end else if (load) begin
            q_valid <= d_valid;
            // Only capture real words so idle slots keep their last value.
            if (d_valid) begin
                q_data <= d_data;
            end
        end
    end

endmodule

// File: rtl/pipe_register.sv
// Purpose: STAGES-deep valid/ready register pipeline with bubble collapse, flush and occupancy count.
// Latency: STAGES cycles input transfer to out_valid when empty; one word per cycle sustained.
// Backpressure: out_ready low stalls the tail; empty slots still fill, in_ready drops only when all slots are held.
module pipe_register
    import pipe_register_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         flush,
    output logic [$clog2(STAGES+1)-1:0]  count
);

    localparam int CW = $clog2(STAGES + 1);

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] ld;
    logic [WIDTH-1:0]  dat [STAGES];
    logic              in_xfer;
    logic              out_xfer;
    logic [CW-1:0]     count_q;

    // A slot loads when it is empty or its own word moves on; walk tail to head.
    always_comb begin
        logic moving;
        ld     = '0;
        moving = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            ld[i]  = ~vld[i] | moving;
            moving = ld[i];
        end
    end

    assign in_ready = reset_n & ~flush & ld[0];
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = vld[STAGES-1] & out_ready & ~flush;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             d_valid;
        logic [WIDTH-1:0] d_data;

        if (i == 0) begin : g_head
            assign d_valid = in_xfer;
            assign d_data  = in_data;
        end else begin : g_body
            assign d_valid = vld[i-1];
            assign d_data  = dat[i-1];
        end

        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .flush   (flush),
            .load    (ld[i]),
            .d_valid (d_valid),
            .d_data  (d_data),
            .q_valid (vld[i]),
            .q_data  (dat[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(in_xfer) - CW'(out_xfer);
        end
    end

    assign out_valid = vld[STAGES-1];
    assign out_data  = dat[STAGES-1];
    assign count     = count_q;

endmodule

// File: tb/tb_pipe_register.sv
// Directed bench for pipe_register at WIDTH=8, STAGES=4.
module tb_pipe_register;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       flush;
    logic [2:0] count;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    pipe_register #(
        .WIDTH  (8),
        .STAGES (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #1;
        step();
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_count", count, 0);
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // Back-to-back stream 0x01..0x0A with out_ready held high.
        out_ready = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            int acc;
            int taken;
            if (e <= 10) begin
                in_valid = 1'b1;
                in_data  = 8'(e);
                #1;
                chk("stream_in_ready", in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            acc   = (e < 10) ? e : 10;
            taken = (e < 5) ? 0 : ((e < 14) ? e - 4 : 10);
            chk("stream_count", count, acc - taken);
            if (e >= 4 && e <= 13) begin
                chk("stream_out_valid", out_valid, 1);
                chk("stream_out_data", out_data, e - 3);
            end else begin
                chk("stream_out_valid", out_valid, 0);
            end
        end

        // Backpressure: offer 0x10..0x15 with a stalled sink.
        out_ready = 1'b0;
        begin
            int idx = 0;
            for (int c = 0; c < 6; c++) begin
                in_valid = 1'b1;
                in_data  = 8'h10 + 8'(idx);
                #1;
                chk("bp_in_ready", in_ready, (idx < 4) ? 1 : 0);
                if (idx < 4) begin
                    step();
                    idx++;
                end else begin
                    step();
                end
            end
        end
        chk("bp_count", count, 4);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_data", out_data, 8'h10);
        chk("bp_hold_in_ready", in_ready, 0);
        // Full pipe with sink ready: simultaneous in/out keeps count at 4.
        out_ready = 1'b1;
        in_data   = 8'h14;
        #1;
        chk("full_in_ready", in_ready, 1);
        step();
        chk("full_count_a", count, 4);
        chk("full_out_a", out_data, 8'h11);
        in_data = 8'h15;
        #1;
        chk("full_in_ready_b", in_ready, 1);
        step();
        chk("full_count_b", count, 4);
        chk("full_out_b", out_data, 8'h12);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k < 3) begin
                chk("drain_valid", out_valid, 1);
                chk("drain_data", out_data, 8'h13 + k);
            end else begin
                chk("drain_empty", out_valid, 0);
            end
            chk("drain_count", count, 3 - k);
        end

        // Bubble collapse: 0xAA, two idle cycles, 0xBB, sink stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("bub_count_a", count, 1);
        chk("bub_valid_a", out_valid, 0);
        in_valid = 1'b1;
        in_data  = 8'hBB;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("bub_count", count, 2);
        chk("bub_out_valid", out_valid, 1);
        chk("bub_out_data", out_data, 8'hAA);
        chk("bub_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        chk("bub_next_valid", out_valid, 1);
        chk("bub_next_data", out_data, 8'hBB);
        chk("bub_next_count", count, 1);
        step();
        chk("bub_empty", out_valid, 0);
        chk("bub_empty_count", count, 0);

        // Flush with three words in flight and 0x55 offered.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h31 + 8'(k);
            step();
        end
        chk("fl_pre_count", count, 3);
        flush   = 1'b1;
        in_data = 8'h55;
        #1;
        chk("fl_in_ready", in_ready, 0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_count", count, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("fl_no_55", out_valid, 0);
        end

        // Mid-stream reset with four words held.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h41 + 8'(k);
            step();
        end
        chk("mr_pre_count", count, 4);
        chk("mr_pre_data", out_data, 8'h41);
        reset_n = 1'b0;
        in_data = 8'h99;
        #1;
        chk("mr_in_ready_rst", in_ready, 0);
        step();
        reset_n  = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_out_data", out_data, 8'h00);
        chk("mr_count", count, 0);
        chk("mr_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        step();
        chk("mr_stays_empty", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
